// File: rtl/blit_mem_write.sv
// blit_mem_write: write-combining line buffer that collects blitter destination bytes
// and writes each SDRAM line out as one masked burst.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   p4_write/addr/data    pixel byte write from the pipeline (held while stall=1)
//   flush                 level request to write out any open line
//   stall                 write not accepted this cycle
//   idle                  no open line and no burst in progress
//   blitw_sdram_req/addr  burst write request and line-aligned address, held until ack
//   blitw_sdram_ack       controller accepted the request
//   blitw_sdram_wrready   controller consumes the current word this cycle
//   blitw_sdram_wdata     current 32-bit word of the line, byte 0 in [7:0]
//   blitw_sdram_wmask     byte enables for wdata
//   blitw_sdram_complete  burst fully written to SDRAM
module blit_mem_write #(
   parameter int ADDR_W     = 26,
   parameter int LINE_BYTES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p4_write,
   input  logic [ADDR_W-1:0] p4_addr,
   input  logic [7:0]        p4_data,
   input  logic              flush,
   output logic              stall,
   output logic              idle,
   output logic              blitw_sdram_req,
   output logic [ADDR_W-1:0] blitw_sdram_addr,
   input  logic              blitw_sdram_ack,
   input  logic              blitw_sdram_wrready,
   output logic [31:0]       blitw_sdram_wdata,
   output logic [3:0]        blitw_sdram_wmask,
   input  logic              blitw_sdram_complete
);
   localparam int OFS_W = $clog2(LINE_BYTES);
   localparam int TAG_W = ADDR_W - OFS_W;
   localparam int PTR_W = OFS_W - 2;

   typedef enum logic [2:0] {EMPTY, FILL, REQ, DATA, DONE_WAIT} state_t;

   state_t                state, state_nx;
   logic [7:0]            line_buf [LINE_BYTES];
   logic [LINE_BYTES-1:0] mask;
   logic [TAG_W-1:0]      tag;
   logic [PTR_W-1:0]      ptr;
   logic [TAG_W-1:0]      in_tag;
   logic [OFS_W-1:0]      in_ofs;
   logic [OFS_W-1:0]      word_base;
   logic                  hit;
   logic                  line_full;
   logic                  open_ok;
   logic                  accept;
   logic                  last_word;

   assign in_tag    = p4_addr[ADDR_W-1:OFS_W];
   assign in_ofs    = p4_addr[OFS_W-1:0];
   assign word_base = {ptr, 2'b00};
   assign hit       = in_tag == tag;
   assign line_full = &mask;
   assign last_word = &ptr;
   // A write can only land in an empty buffer or in the open line while it still has room
   assign open_ok   = state == EMPTY || (state == FILL && hit && !line_full);
   assign accept    = p4_write && !reset && open_ok;

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:     if (p4_write) state_nx = FILL;
         FILL:      if (line_full || (p4_write && !hit) || (flush && !p4_write)) state_nx = REQ;
         REQ:       if (blitw_sdram_ack) state_nx = DATA;
         // complete may coincide with the last word; skip DONE_WAIT then
         DATA:      if (blitw_sdram_wrready && last_word) state_nx = blitw_sdram_complete ? EMPTY : DONE_WAIT;
         DONE_WAIT: if (blitw_sdram_complete) state_nx = EMPTY;
         default:   state_nx = EMPTY;
      endcase
   end

   always_comb begin
      idle              = state == EMPTY;
      stall             = p4_write && !reset && !open_ok;
      blitw_sdram_wdata = {line_buf[word_base + OFS_W'(3)], line_buf[word_base + OFS_W'(2)],
                           line_buf[word_base + OFS_W'(1)], line_buf[word_base]};
      blitw_sdram_wmask = state == DATA ? mask[word_base +: 4] : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask             <= '0;
         tag              <= '0;
         ptr              <= '0;
         blitw_sdram_req  <= 1'b0;
         blitw_sdram_addr <= '0;
      end else begin
         if (accept) begin
            mask[in_ofs] <= 1'b1;
            if (state == EMPTY) tag <= in_tag;
         end
         if (state == FILL && state_nx == REQ) begin
            blitw_sdram_req  <= 1'b1;
            blitw_sdram_addr <= {tag, {OFS_W{1'b0}}};
         end
         if (state == REQ && blitw_sdram_ack) begin
            blitw_sdram_req <= 1'b0;
            ptr             <= '0;
         end
         if (state == DATA && blitw_sdram_wrready) ptr <= ptr + PTR_W'(1);
         if (state != EMPTY && state_nx == EMPTY) mask <= '0;
      end
   end

   // Byte storage needs no reset: the mask alone says which bytes are live
   always_ff @(posedge clk) begin
      if (accept) line_buf[in_ofs] <= p4_data;
   end
endmodule

// File: tb/tb_blit_mem_write.sv
// tb_blit_mem_write: directed and random checks of blit_mem_write against a line-level model.
module tb_blit_mem_write;
   localparam int AW = 26;
   localparam int LB = 64;
   localparam int NW = LB / 4;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [8*LB-1:0] data;
      logic [LB-1:0]   mask;
   } burst_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          p4_write = 1'b0;
   logic [AW-1:0] p4_addr = '0;
   logic [7:0]    p4_data = '0;
   logic          flush = 1'b0;
   logic          ack = 1'b0;
   logic          wrready = 1'b0;
   logic          complete = 1'b0;
   logic          stall, idle, req;
   logic [AW-1:0] sd_addr;
   logic [31:0]   wdata;
   logic [3:0]    wmask;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   blit_mem_write #(.ADDR_W(AW), .LINE_BYTES(LB)) dut (
      .clk(clk), .reset(reset), .p4_write(p4_write), .p4_addr(p4_addr), .p4_data(p4_data),
      .flush(flush), .stall(stall), .idle(idle), .blitw_sdram_req(req), .blitw_sdram_addr(sd_addr),
      .blitw_sdram_ack(ack), .blitw_sdram_wrready(wrready), .blitw_sdram_wdata(wdata),
      .blitw_sdram_wmask(wmask), .blitw_sdram_complete(complete)
   );

   burst_t exp_q[$];
   burst_t rcv_q[$];
   burst_t last_b;

   // Line-level reference: an open line is a byte array plus written-byte set
   bit            m_open = 0;
   logic [AW-1:0] m_line;
   logic [7:0]    m_bytes [LB];
   logic [LB-1:0] m_mask;

   function automatic void m_close();
      burst_t b;
      if (!m_open) return;
      b.addr = m_line;
      b.mask = m_mask;
      b.data = '0;
      for (int i = 0; i < LB; i++) if (m_mask[i]) b.data[8*i +: 8] = m_bytes[i];
      exp_q.push_back(b);
      m_open = 0;
   endfunction

   function automatic void m_write(input logic [AW-1:0] a, input logic [7:0] d);
      logic [AW-1:0] base = (a / LB) * LB;
      int            off = int'(a % LB);
      if (m_open && base != m_line) m_close();
      if (!m_open) begin
         m_open = 1;
         m_line = base;
         m_mask = '0;
      end
      m_bytes[off] = d;
      m_mask[off] = 1'b1;
      if (&m_mask) m_close();
   endfunction

   task automatic check(input string tag, input logic [8*LB-1:0] obs, input logic [8*LB-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SDRAM controller responder: random ack delay, random wrready, random completion
   int     ack_hold = -1;
   int     phase = 0;
   int     cnt = 0;
   int     nwords = 0;
   bit     early = 0;
   burst_t cur;
   logic [AW-1:0] req_addr;

   initial forever begin
      @(negedge clk);
      ack = 1'b0;
      wrready = 1'b0;
      complete = 1'b0;
      if (reset) phase = 0;
      else if (phase == 0) begin
         if (req) begin
            req_addr = sd_addr;
            cnt = ack_hold >= 0 ? ack_hold : int'($urandom_range(0, 3));
            phase = 1;
         end
      end else if (phase == 1) begin
         check("req_held", req, 1'b1);
         check("addr_held", sd_addr, req_addr);
         if (cnt == 0) begin
            ack = 1'b1;
            cur.addr = sd_addr;
            cur.mask = '0;
            cur.data = '0;
            nwords = 0;
            early = $urandom_range(0, 1) == 1;
            phase = 2;
         end else cnt--;
      end else if (phase == 2) begin
         check("req_low_in_data", req, 1'b0);
         wrready = $urandom_range(0, 2) != 0;
         if (wrready) begin
            for (int b = 0; b < 4; b++) if (wmask[b]) begin
               cur.mask[4*nwords + b] = 1'b1;
               cur.data[32*nwords + 8*b +: 8] = wdata[8*b +: 8];
            end
            nwords++;
            if (nwords == NW) begin
               if (early) begin
                  complete = 1'b1;
                  rcv_q.push_back(cur);
                  phase = 0;
               end else begin
                  cnt = $urandom_range(0, 4);
                  phase = 3;
               end
            end
         end
      end else if (phase == 3) begin
         if (cnt == 0) begin
            complete = 1'b1;
            rcv_q.push_back(cur);
            phase = 0;
         end else cnt--;
      end
   end

   task automatic wr(input logic [AW-1:0] a, input logic [7:0] d, input bit exp_stall = 0);
      int n = 0;
      @(negedge clk);
      p4_write = 1'b1;
      p4_addr = a;
      p4_data = d;
      #1;
      if (exp_stall) check("stall_on_miss", stall, 1'b1);
      while (stall && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wr_accept", stall, 1'b0);
      @(posedge clk);
      #1;
      p4_write = 1'b0;
      m_write(a, d);
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      m_close();
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!idle && n < 500);
      check("idle_reached", idle, 1'b1);
   endtask

   task automatic drain();
      check("burst_count", rcv_q.size(), exp_q.size());
      while (rcv_q.size() > 0 && exp_q.size() > 0) begin
         burst_t r = rcv_q.pop_front();
         burst_t e = exp_q.pop_front();
         check("burst_addr", r.addr, e.addr);
         check("burst_mask", r.mask, e.mask);
         check("burst_data", r.data, e.data);
         last_b = r;
      end
      rcv_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [AW-1:0] base;
      repeat (3) @(negedge clk);
      #1;
      check("rst_idle", idle, 1'b1);
      check("rst_stall", stall, 1'b0);
      check("rst_req", req, 1'b0);
      check("rst_addr", sd_addr, '0);
      check("rst_wmask", wmask, 4'h0);
      @(negedge clk);
      reset = 1'b0;

      // four bytes in one line, then flush
      wr(26'h100, 8'hAA);
      wr(26'h101, 8'hBB);
      wr(26'h102, 8'hCC);
      wr(26'h103, 8'hDD);
      do_flush();
      wait_idle();
      drain();
      check("t1_addr", last_b.addr, 26'h100);
      check("t1_word0", last_b.data[31:0], 32'hDDCCBBAA);
      check("t1_mask", last_b.mask, 64'hF);

      // line change stalls until the old line is written
      wr(26'h140, 8'h11);
      wr(26'h180, 8'h22, 1);
      check("t2_open", idle, 1'b0);
      do_flush();
      wait_idle();
      drain();
      check("t2_addr", last_b.addr, 26'h180);

      // full line flushes by itself
      for (int i = 0; i < LB; i++) wr(AW'(i), 8'($urandom));
      check("t3_req_before", req, 1'b0);
      @(posedge clk);
      #1;
      check("t3_req_after", req, 1'b1);
      check("t3_addr", sd_addr, 26'h0);
      wait_idle();
      drain();
      check("t3_fullmask", last_b.mask, {LB{1'b1}});

      // repeat write: last data wins
      wr(26'h205, 8'h11);
      wr(26'h205, 8'h77);
      do_flush();
      wait_idle();
      drain();
      check("t4_w1mask", last_b.mask[7:4], 4'h2);
      check("t4_byte", last_b.data[47:40], 8'h77);

      // long ack hold-off
      ack_hold = 10;
      wr(26'h2C7, 8'h3E);
      wr(26'h2F0, 8'hC1);
      do_flush();
      wait_idle();
      drain();
      ack_hold = -1;

      // reset in the middle of a burst
      wr(26'h3C0, 8'h99);
      do_flush();
      n = 0;
      while (phase != 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t6_in_data", phase, 2);
      @(negedge clk);
      reset = 1'b1;
      p4_write = 1'b1;
      p4_addr = 26'h3C1;
      p4_data = 8'h5A;
      #1;
      check("t6_stall_in_reset", stall, 1'b0);
      @(posedge clk);
      #1;
      check("t6_req", req, 1'b0);
      check("t6_idle", idle, 1'b1);
      void'(exp_q.pop_back());
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_stall_after", stall, 1'b0);
      @(posedge clk);
      #1;
      p4_write = 1'b0;
      m_write(26'h3C1, 8'h5A);
      check("t6_fresh_line", idle, 1'b0);
      do_flush();
      wait_idle();
      drain();
      check("t6_mask", last_b.mask, 64'h2);

      // random traffic over a few neighbouring lines
      for (int k = 0; k < 300; k++) begin
         base = 26'h1000 + AW'($urandom_range(0, 3) * LB);
         wr(base + AW'($urandom_range(0, LB - 1)), 8'($urandom));
         if ($urandom_range(0, 19) == 0) do_flush();
      end
      do_flush();
      wait_idle();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
